i2s_stereo_rx: RTL
==================

// Module: i2s_stereo_rx
// PURPOSE
//  Deserialises the codec ADC I2S stream (bclk/lrck/adcdat, asynchronous to clk) into signed
//  stereo sample pairs for the effects chain. Its outputs drive leftSampleIn/rightSampleIn of the
//  distortion stage. sample_valid gives a one-cycle strobe per completed frame.
//  Handles codec word lengths above/below DATA_W. Detects loss of bclk and re-locks.
// PARAMETERS
//  DATA_W       16    output sample width; MSB-first, left-justified capture
//  SYNC_STAGES  2     flip-flop stages on bclk, lrck and adcdat (>=2)
//  TIMEOUT_CYC  1024  clk cycles without a bclk rise before the block declares link lost
// PORTS
//  clk             in   1       system clock; bclk high and low phases each >= SYNC_STAGES+1 clk periods
//  reset_n         in   1       synchronous, active-low reset
//  bclk            in   1       codec bit clock (async)
//  lrck            in   1       codec word select (async); 0 = left, 1 = right
//  adcdat          in   1       codec serial data (async)
//  leftSampleOut   out  DATA_W  signed left sample, held between frames
//  rightSampleOut  out  DATA_W  signed right sample, held between frames
//  sample_valid    out  1       1-cycle pulse; both sample outputs update in that cycle
//  locked          out  1       1 when frame-aligned (state != SYNC)
//  short_frame     out  1       qualified by sample_valid; 1 if either word had < DATA_W bits
// BEHAVIOUR
//  Reset: all outputs 0, state SYNC, bit_cnt 0, shift register 0, timeout counter 0.
//    Reset mid-frame discards the partial data.
//  Sampling:
//    - bclk, lrck and adcdat each pass through SYNC_STAGES flops.
//    - A rising edge of synchronised bclk is a "rise" event.
//    - At each rise, lrck_s and dat_s are sampled together. lrck_q holds lrck_s from the previous rise.
//  Per rise, in this order:
//    1. If bit_cnt < DATA_W: sreg <= {sreg, dat_s}; bit_cnt++. Bits beyond DATA_W are dropped.
//    2. If lrck_s != lrck_q, a boundary is detected:
//       - Commit word = sreg (including step-1 bit) << (DATA_W - bit_cnt), zero-filled.
//       - Set the short flag if bit_cnt < DATA_W.
//       - Set bit_cnt = 0.
//    This implements the I2S one-bclk delay: the rise that sees the new lrck carries the
//    previous word's last bit, and the next rise carries the new MSB.
//  FSM states: SYNC, LEFT, RIGHT.
//    - SYNC:  discard everything. On a boundary with lrck_s = 0, go to LEFT.
//    - LEFT:  on a boundary (lrck_s = 1), hold left word and its short flag; go to RIGHT.
//    - RIGHT: on a boundary (lrck_s = 0):
//        * drive leftSampleOut = held left word, rightSampleOut = committed word;
//        * short_frame = OR of both short flags;
//        * pulse sample_valid; go to LEFT.
//  Latency: sample_valid asserts SYNC_STAGES+2 clk cycles after raw bclk rises at the frame-ending boundary.
//  Timeout:
//    - The counter clears on every rise and saturates at TIMEOUT_CYC.
//    - On reaching TIMEOUT_CYC in any state: go to SYNC and set bit_cnt = 0.
//    - locked goes 0 in the next cycle. Sample outputs hold their last values. No sample_valid until re-aligned.
//  After reset or timeout, the first sample_valid follows the first complete left+right pair after an lrck 1->0 boundary.
//  sample_valid is never asserted in two consecutive cycles.
//  sample_valid is never asserted while reset_n = 0.
// STRUCTURE
//  Shared audio_pkg holds:
//    - SAMPLE_W = 16;
//    - typedef logic signed [SAMPLE_W-1:0] sample_t;
//    - typedef enum logic [1:0] {RX_SYNC, RX_LEFT, RX_RIGHT} i2s_rx_state_t.
//  Sub-module sync_edge_det: N-stage synchroniser plus rising-edge pulse. Used for bclk;
//    lrck and adcdat use its synchroniser output only. Keeps the three paths equally delayed.
//  Top level: shift register, bit counter, FSM, timeout counter, output registers.
// TESTING
//  1. 32 bclk/frame, left = 16'h8001, right = 16'h7FFE, 4 frames ->
//     - 3 sample_valid pulses after lock, outputs 8001/7FFE;
//     - short_frame = 0; locked = 1 from the first 1->0 boundary.
//  2. 64 bclk/frame, 24-bit words, left = 24'h123456, right = 24'hFEDCBA -> outputs 16'h1234 / 16'hFEDC.
//  3. 24 bclk/frame, 12-bit words, left = 12'hABC, right = 12'h7FF -> outputs 16'hABC0 / 16'h7FF0 with short_frame = 1.
//  4. reset_n low for 1 cycle mid-right-word -> next cycle:
//     - all outputs 0, locked = 0;
//     - no sample_valid until a full left+right pair follows the next lrck 1->0 edge.
//  5. bclk stopped for TIMEOUT_CYC+10 clk -> locked falls, outputs hold, no sample_valid.
//     Restart bclk -> relock and correct data on the first full frame.
//  6. bclk = clk/(2*(SYNC_STAGES+1)) with a random data stream -> every frame is captured exactly,
//     with one sample_valid per frame.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types: sample width, signed sample type and I2S receiver FSM states.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {RX_SYNC, RX_LEFT, RX_RIGHT} i2s_rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for one edge-detected line plus WIDTH companion data lines.
// All lines share one delay so the rise pulse and the data it qualifies stay aligned.
module sync_edge_det #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_edge,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_rise
);

    logic [WIDTH:0] r_stage [STAGES];
    logic [WIDTH:0] r_dly;
    logic           r_rise;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
            r_dly  <= '0;
            r_rise <= 1'b0;
        end else begin
            r_stage[0] <= {i_edge, i_data};
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            // Extra stage keeps the rise pulse aligned with the data sampled with it.
            r_dly  <= r_stage[STAGES-1];
            r_rise <= r_stage[STAGES-1][WIDTH] & ~r_dly[WIDTH];
        end
    end

    assign o_data = r_dly[WIDTH-1:0];
    assign o_rise = r_rise;

endmodule

// File: rtl/i2s_stereo_rx.sv
// I2S stereo receiver: deserialises left/right words into left-justified DATA_W samples,
// strobes sample_valid once per frame and drops lock when bclk stops.
module i2s_stereo_rx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bclk,
    input  logic              lrck,
    input  logic              adcdat,
    output logic [DATA_W-1:0] leftSampleOut,
    output logic [DATA_W-1:0] rightSampleOut,
    output logic              sample_valid,
    output logic              locked,
    output logic              short_frame
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]        w_sync_data;
    logic              w_rise;
    logic              w_lrck_s;
    logic              w_dat_s;

    i2s_rx_state_t     r_state;
    i2s_rx_state_t     w_state_d;

    logic [DATA_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_lrck_q;
    logic [DATA_W-1:0] r_left_hold;
    logic              r_left_short;
    logic [TO_W-1:0]   r_timeout;
    logic [DATA_W-1:0] r_left_out;
    logic [DATA_W-1:0] r_right_out;
    logic              r_valid;
    logic              r_short;

    logic [DATA_W-1:0] w_sreg_d;
    logic [CNT_W-1:0]  w_bit_cnt_d;
    logic              w_lrck_q_d;
    logic [DATA_W-1:0] w_left_hold_d;
    logic              w_left_short_d;
    logic [TO_W-1:0]   w_timeout_d;
    logic [DATA_W-1:0] w_left_out_d;
    logic [DATA_W-1:0] w_right_out_d;
    logic              w_valid_d;
    logic              w_short_d;

    logic              w_take;
    logic [DATA_W-1:0] w_sreg_shift;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [DATA_W-1:0] w_commit;
    logic              w_word_short;
    logic              w_boundary;
    logic              w_timeout;

    sync_edge_det #(
        .WIDTH  (2),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_edge    (bclk),
        .i_data    ({lrck, adcdat}),
        .o_data    (w_sync_data),
        .o_rise    (w_rise)
    );

    assign w_lrck_s = w_sync_data[1];
    assign w_dat_s  = w_sync_data[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RX_SYNC;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_take       = r_bit_cnt < CNT_W'(DATA_W);
        w_sreg_shift = w_take ? {r_sreg[DATA_W-2:0], w_dat_s} : r_sreg;
        w_cnt_inc    = w_take ? r_bit_cnt + CNT_W'(1) : r_bit_cnt;
        // Short words are left-justified with zero fill.
        w_commit     = w_sreg_shift << (CNT_W'(DATA_W) - w_cnt_inc);
        w_word_short = w_cnt_inc < CNT_W'(DATA_W);
        w_boundary   = w_lrck_s != r_lrck_q;
        w_timeout    = r_timeout == TO_W'(TIMEOUT_CYC);

        w_state_d      = r_state;
        w_sreg_d       = r_sreg;
        w_bit_cnt_d    = r_bit_cnt;
        w_lrck_q_d     = r_lrck_q;
        w_left_hold_d  = r_left_hold;
        w_left_short_d = r_left_short;
        w_timeout_d    = r_timeout;
        w_left_out_d   = r_left_out;
        w_right_out_d  = r_right_out;
        w_valid_d      = 1'b0;
        w_short_d      = r_short;

        if (w_rise) begin
            w_timeout_d = '0;
            w_sreg_d    = w_sreg_shift;
            w_bit_cnt_d = w_cnt_inc;
            w_lrck_q_d  = w_lrck_s;
            if (w_boundary) begin
                w_bit_cnt_d = '0;
                unique case (r_state)
                    RX_SYNC: begin
                        if (!w_lrck_s) begin
                            w_state_d = RX_LEFT;
                        end
                    end
                    RX_LEFT: begin
                        if (w_lrck_s) begin
                            w_left_hold_d  = w_commit;
                            w_left_short_d = w_word_short;
                            w_state_d      = RX_RIGHT;
                        end
                    end
                    RX_RIGHT: begin
                        if (!w_lrck_s) begin
                            w_left_out_d  = r_left_hold;
                            w_right_out_d = w_commit;
                            w_short_d     = r_left_short | w_word_short;
                            w_valid_d     = 1'b1;
                            w_state_d     = RX_LEFT;
                        end
                    end
                    default: w_state_d = RX_SYNC;
                endcase
            end
        end else if (w_timeout) begin
            w_state_d   = RX_SYNC;
            w_bit_cnt_d = '0;
        end else begin
            w_timeout_d = r_timeout + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_lrck_q     <= 1'b0;
            r_left_hold  <= '0;
            r_left_short <= 1'b0;
            r_timeout    <= '0;
            r_left_out   <= '0;
            r_right_out  <= '0;
            r_valid      <= 1'b0;
            r_short      <= 1'b0;
        end else begin
            r_sreg       <= w_sreg_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_lrck_q     <= w_lrck_q_d;
            r_left_hold  <= w_left_hold_d;
            r_left_short <= w_left_short_d;
            r_timeout    <= w_timeout_d;
            r_left_out   <= w_left_out_d;
            r_right_out  <= w_right_out_d;
            r_valid      <= w_valid_d;
            r_short      <= w_short_d;
        end
    end

    assign leftSampleOut  = r_left_out;
    assign rightSampleOut = r_right_out;
    assign sample_valid   = r_valid;
    assign short_frame    = r_short;
    assign locked         = r_state != RX_SYNC;

endmodule
